// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM encoding, datapath widths and the PC alignment helper.
package instr_fetch_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Redirect targets may carry junk in the byte-offset bits; fetches are always word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port: single-outstanding request/acknowledge word reads.
// The fetch stage is the master; the memory (or bench model) is the slave.
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic               req;
    logic [31:0]        addr;
    logic               ack;
    logic [INSTR_W-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );

endinterface

// File: rtl/instr_fetch_ir_skid_buf.sv
// One-entry data+PC buffer that parks a returning instruction word while decode is stalled.
// Clear and unload both empty the entry; either wins over a simultaneous load.
module ir_skid_buf
    import instr_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               unload,
    input  logic               clear,
    input  logic [INSTR_W-1:0] load_data,
    input  logic [31:0]        load_pc,
    output logic [INSTR_W-1:0] data,
    output logic [31:0]        pc,
    output logic               valid
);

    logic [INSTR_W-1:0] data_r;
    logic [31:0]        pc_r;
    logic               valid_r;

    // Entry storage: payload only changes on load, occupancy tracks load/unload/clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r  <= {INSTR_W{1'b0}};
            pc_r    <= 32'h0000_0000;
            valid_r <= 1'b0;
        end else if (clear || unload) begin
            valid_r <= 1'b0;
        end else if (load) begin
            data_r  <= load_data;
            pc_r    <= load_pc;
            valid_r <= 1'b1;
        end
    end

    assign data  = data_r;
    assign pc    = pc_r;
    assign valid = valid_r;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the fetch PC, issues single-outstanding word reads and presents IR/PC to decode.
// A skid entry absorbs a word returning under stall; redirects kill any in-flight or buffered data.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)
(
    input  logic               clk,
    input  logic               rst,
    instr_fetch_if.master      imem,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               ir_valid,
    output logic [INSTR_W-1:0] ir,
    output logic [31:0]        ir_pc,
    output logic [31:0]        ir_pc4
);

    fetch_state_t       state_r,  state_n;
    logic [31:0]        fetch_pc_r, fetch_pc_n;
    logic [31:0]        pend_pc_r,  pend_pc_n;
    logic [INSTR_W-1:0] ir_r,       ir_n;
    logic [31:0]        ir_pc_r,    ir_pc_n;
    logic               ir_valid_r, ir_valid_n;

    logic               slot_free_s;
    logic [31:0]        target_s;
    logic [31:0]        pc_next_s;

    logic               skid_load_s;
    logic               skid_unload_s;
    logic               skid_clear_s;
    logic [INSTR_W-1:0] skid_data_s;
    logic [31:0]        skid_pc_s;
    logic               skid_valid_s;

    assign slot_free_s = !ir_valid_r || !stall;
    assign target_s    = align_word(redirect_pc);
    assign pc_next_s   = fetch_pc_r + PC_STEP;

    ir_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load_s),
        .unload    (skid_unload_s),
        .clear     (skid_clear_s),
        .load_data (imem.rdata),
        .load_pc   (fetch_pc_r),
        .data      (skid_data_s),
        .pc        (skid_pc_s),
        .valid     (skid_valid_s)
    );

    // State, PC and instruction-register storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= FETCH;
            fetch_pc_r <= RESET_PC;
            pend_pc_r  <= RESET_PC;
            ir_r       <= {INSTR_W{1'b0}};
            ir_pc_r    <= 32'h0000_0000;
            ir_valid_r <= 1'b0;
        end else begin
            state_r    <= state_n;
            fetch_pc_r <= fetch_pc_n;
            pend_pc_r  <= pend_pc_n;
            ir_r       <= ir_n;
            ir_pc_r    <= ir_pc_n;
            ir_valid_r <= ir_valid_n;
        end
    end

    // Next-state logic; a consumed IR empties unless refilled, and redirect outranks ack and stall.
    always_comb begin
        state_n       = state_r;
        fetch_pc_n    = fetch_pc_r;
        pend_pc_n     = pend_pc_r;
        ir_n          = ir_r;
        ir_pc_n       = ir_pc_r;
        ir_valid_n    = ir_valid_r && stall;
        skid_load_s   = 1'b0;
        skid_unload_s = 1'b0;
        skid_clear_s  = 1'b0;

        case (state_r)
            FETCH: begin
                if (redirect && imem.ack) begin
                    fetch_pc_n = target_s;
                    ir_valid_n = 1'b0;
                end else if (redirect) begin
                    // Request is still open: keep the address, remember where to go afterwards.
                    pend_pc_n  = target_s;
                    ir_valid_n = 1'b0;
                    state_n    = DRAIN;
                end else if (imem.ack && slot_free_s) begin
                    ir_n       = imem.rdata;
                    ir_pc_n    = fetch_pc_r;
                    ir_valid_n = 1'b1;
                    fetch_pc_n = pc_next_s;
                end else if (imem.ack) begin
                    skid_load_s = 1'b1;
                    fetch_pc_n  = pc_next_s;
                    state_n     = HOLD;
                end else begin
                    state_n = FETCH;
                end
            end

            HOLD: begin
                if (redirect) begin
                    skid_clear_s = 1'b1;
                    fetch_pc_n   = target_s;
                    ir_valid_n   = 1'b0;
                    state_n      = FETCH;
                end else if (!stall) begin
                    if (skid_valid_s) begin
                        ir_n       = skid_data_s;
                        ir_pc_n    = skid_pc_s;
                        ir_valid_n = 1'b1;
                    end else begin
                        ir_valid_n = 1'b0;
                    end
                    skid_unload_s = 1'b1;
                    state_n       = FETCH;
                end else begin
                    state_n = HOLD;
                end
            end

            DRAIN: begin
                ir_valid_n = 1'b0;
                if (redirect && imem.ack) begin
                    fetch_pc_n = target_s;
                    state_n    = FETCH;
                end else if (redirect) begin
                    pend_pc_n = target_s;
                end else if (imem.ack) begin
                    fetch_pc_n = pend_pc_r;
                    state_n    = FETCH;
                end else begin
                    state_n = DRAIN;
                end
            end

            default: begin
                state_n    = FETCH;
                ir_valid_n = 1'b0;
            end
        endcase
    end

    // Request drops combinationally with reset so an abandoned read never lingers.
    assign imem.req  = !rst && (state_r != HOLD);
    assign imem.addr = fetch_pc_r;

    assign ir_valid = ir_valid_r;
    assign ir       = ir_r;
    assign ir_pc    = ir_pc_r;
    assign ir_pc4   = ir_pc_r + PC_STEP;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized run against
// a program-order reference model (expected PC stream advanced by 4, retargeted on redirect).
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ir_valid;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic [31:0] ir_pc4;

    int total = 0;
    int bad   = 0;

    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (bus),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ir_valid    (ir_valid),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_pc4      (ir_pc4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic idle_inputs();
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        bus.ack     = 1'b0;
        bus.rdata   = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        #1;
        total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", bus.req); end
        total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ir_valid); end
        total++; if (ir !== 32'h0) begin bad++; $display("FAIL reset_ir got=%h exp=0", ir); end
        total++; if (ir_pc !== 32'h0) begin bad++; $display("FAIL reset_ir_pc got=%h exp=0", ir_pc); end
        rst = 1'b0;
        #1;
        total++; if (bus.req !== 1'b1) begin bad++; $display("FAIL release_req got=%b exp=1", bus.req); end
        total++; if (bus.addr !== 32'h0000_3000) begin bad++; $display("FAIL release_addr got=%h exp=00003000", bus.addr); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            exp = 32'h0000_3000 + 32'(i * 4);
            total++; if (bus.req !== 1'b1 || bus.addr !== exp) begin bad++; $display("FAIL seq_addr got=%b/%h exp=1/%h", bus.req, bus.addr, exp); end
            bus.ack   = 1'b1;
            bus.rdata = word_at(bus.addr);
            @(negedge clk);
            bus.ack = 1'b0;
            total++; if (ir_valid !== 1'b1 || ir_pc !== exp || ir !== word_at(exp)) begin bad++; $display("FAIL seq_ir got=%b/%h/%h exp=1/%h/%h", ir_valid, ir_pc, ir, exp, word_at(exp)); end
        end
    endtask

    task automatic test_stall_hold();
        do_reset();
        bus.ack   = 1'b1;
        bus.rdata = word_at(32'h0000_3000);
        @(negedge clk);
        total++; if (bus.addr !== 32'h0000_3004) begin bad++; $display("FAIL hold_pre_addr got=%h exp=00003004", bus.addr); end
        stall     = 1'b1;
        bus.ack   = 1'b1;
        bus.rdata = word_at(32'h0000_3004);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.ack = 1'b0;
            total++; if (bus.req !== 1'b0 || ir_valid !== 1'b1 || ir !== word_at(32'h0000_3000)) begin bad++; $display("FAIL hold_stalled got=%b/%b/%h exp=0/1/%h", bus.req, ir_valid, ir, word_at(32'h0000_3000)); end
        end
        stall = 1'b0;
        @(negedge clk);
        total++; if (ir_valid !== 1'b1 || ir_pc !== 32'h0000_3004 || ir !== word_at(32'h0000_3004)) begin bad++; $display("FAIL hold_release_ir got=%b/%h/%h exp=1/00003004/%h", ir_valid, ir_pc, ir, word_at(32'h0000_3004)); end
        total++; if (bus.req !== 1'b1 || bus.addr !== 32'h0000_3008) begin bad++; $display("FAIL hold_release_addr got=%b/%h exp=1/00003008", bus.req, bus.addr); end
    endtask

    task automatic test_redirect_pending();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.ack   = 1'b1;
            bus.rdata = word_at(bus.addr);
            @(negedge clk);
        end
        bus.ack = 1'b0;
        total++; if (bus.addr !== 32'h0000_3010) begin bad++; $display("FAIL drain_pre_addr got=%h exp=00003010", bus.addr); end
        redirect    = 1'b1;
        redirect_pc = 32'h0000_4002;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            redirect = 1'b0;
            total++; if (bus.req !== 1'b1 || bus.addr !== 32'h0000_3010 || ir_valid !== 1'b0) begin bad++; $display("FAIL drain_wait got=%b/%h/%b exp=1/00003010/0", bus.req, bus.addr, ir_valid); end
        end
        bus.ack   = 1'b1;
        bus.rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.ack = 1'b0;
        total++; if (bus.req !== 1'b1 || bus.addr !== 32'h0000_4000 || ir_valid !== 1'b0) begin bad++; $display("FAIL drain_done got=%b/%h/%b exp=1/00004000/0", bus.req, bus.addr, ir_valid); end
        bus.ack   = 1'b1;
        bus.rdata = word_at(32'h0000_4000);
        @(negedge clk);
        bus.ack = 1'b0;
        total++; if (ir_valid !== 1'b1 || ir_pc !== 32'h0000_4000 || ir !== word_at(32'h0000_4000)) begin bad++; $display("FAIL drain_target_ir got=%b/%h/%h exp=1/00004000/%h", ir_valid, ir_pc, ir, word_at(32'h0000_4000)); end
    endtask

    task automatic test_redirect_with_ack();
        do_reset();
        bus.ack   = 1'b1;
        bus.rdata = word_at(32'h0000_3000);
        @(negedge clk);
        stall       = 1'b1;
        bus.rdata   = word_at(32'h0000_3004);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_5000;
        @(negedge clk);
        bus.ack  = 1'b0;
        redirect = 1'b0;
        total++; if (ir_valid !== 1'b0 || bus.req !== 1'b1 || bus.addr !== 32'h0000_5000) begin bad++; $display("FAIL redir_ack got=%b/%b/%h exp=0/1/00005000", ir_valid, bus.req, bus.addr); end
        stall     = 1'b0;
        bus.ack   = 1'b1;
        bus.rdata = word_at(32'h0000_5000);
        @(negedge clk);
        bus.ack = 1'b0;
        total++; if (ir_valid !== 1'b1 || ir_pc !== 32'h0000_5000 || ir !== word_at(32'h0000_5000)) begin bad++; $display("FAIL redir_ack_ir got=%b/%h/%h exp=1/00005000/%h", ir_valid, ir_pc, ir, word_at(32'h0000_5000)); end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        bus.ack     = 1'b1;
        bus.rdata   = 32'h0BAD_0BAD;
        @(negedge clk);
        redirect = 1'b0;
        total++; if (bus.addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr got=%h exp=fffffffc", bus.addr); end
        bus.rdata = word_at(32'hFFFF_FFFC);
        @(negedge clk);
        total++; if (ir_pc !== 32'hFFFF_FFFC || ir_pc4 !== 32'h0 || bus.addr !== 32'h0) begin bad++; $display("FAIL wrap_first got=%h/%h/%h exp=fffffffc/0/0", ir_pc, ir_pc4, bus.addr); end
        bus.rdata = word_at(32'h0);
        @(negedge clk);
        bus.ack = 1'b0;
        total++; if (ir_valid !== 1'b1 || ir_pc !== 32'h0 || ir !== word_at(32'h0) || ir_pc4 !== 32'h4) begin bad++; $display("FAIL wrap_second got=%b/%h/%h/%h exp=1/0/%h/4", ir_valid, ir_pc, ir, ir_pc4, word_at(32'h0)); end
    endtask

    task automatic test_reset_in_drain();
        do_reset();
        bus.ack   = 1'b1;
        bus.rdata = word_at(32'h0000_3000);
        @(negedge clk);
        bus.ack     = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_6000;
        @(negedge clk);
        redirect = 1'b0;
        total++; if (bus.req !== 1'b1 || bus.addr !== 32'h0000_3004) begin bad++; $display("FAIL rst_drain_pre got=%b/%h exp=1/00003004", bus.req, bus.addr); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus.req !== 1'b0 || ir_valid !== 1'b0) begin bad++; $display("FAIL rst_drain_async got=%b/%b exp=0/0", bus.req, ir_valid); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (bus.req !== 1'b1 || bus.addr !== 32'h0000_3000) begin bad++; $display("FAIL rst_drain_restart got=%b/%h exp=1/00003000", bus.req, bus.addr); end
        bus.ack   = 1'b1;
        bus.rdata = word_at(32'h0000_3000);
        @(negedge clk);
        bus.ack = 1'b0;
        total++; if (ir_valid !== 1'b1 || ir_pc !== 32'h0000_3000) begin bad++; $display("FAIL rst_drain_ir got=%b/%h exp=1/00003000", ir_valid, ir_pc); end
    endtask

    task automatic test_random();
        logic [31:0] model_pc;
        logic        discard_pending;
        logic        discard;
        logic        prev_redirect, prev_req, prev_ack, prev_valid, prev_stall;
        logic        prev_discard, prev_slot_free;
        logic [31:0] prev_addr, prev_ir, prev_ir_pc;
        int          consumed;
        do_reset();
        model_pc        = 32'h0000_3000;
        discard_pending = 1'b0;
        consumed        = 0;
        prev_redirect = 1'b0; prev_req = 1'b0; prev_ack = 1'b0; prev_valid = 1'b0;
        prev_stall = 1'b0; prev_discard = 1'b0; prev_slot_free = 1'b0;
        prev_addr = 32'h0; prev_ir = 32'h0; prev_ir_pc = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (prev_redirect) begin
                total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL rnd_redirect_kill cyc=%0d got=%b exp=0", cyc, ir_valid); end
            end
            if (prev_req && !prev_ack) begin
                total++; if (bus.req !== 1'b1 || bus.addr !== prev_addr) begin bad++; $display("FAIL rnd_req_stable cyc=%0d got=%b/%h exp=1/%h", cyc, bus.req, bus.addr, prev_addr); end
            end
            if (prev_valid && prev_stall && !prev_redirect) begin
                total++; if (ir_valid !== 1'b1 || ir !== prev_ir || ir_pc !== prev_ir_pc) begin bad++; $display("FAIL rnd_stall_hold cyc=%0d got=%b/%h/%h exp=1/%h/%h", cyc, ir_valid, ir, ir_pc, prev_ir, prev_ir_pc); end
            end
            if (prev_ack && !prev_discard && prev_slot_free) begin
                total++; if (ir_valid !== 1'b1 || ir_pc !== prev_addr || ir !== word_at(prev_addr)) begin bad++; $display("FAIL rnd_latency cyc=%0d got=%b/%h/%h exp=1/%h/%h", cyc, ir_valid, ir_pc, ir, prev_addr, word_at(prev_addr)); end
            end

            stall    = ($urandom_range(2, 0) == 0);
            redirect = ($urandom_range(9, 0) == 0);
            if ($urandom_range(3, 0) == 0) redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(15, 0));
            else                           redirect_pc = $urandom;
            bus.ack   = bus.req && ($urandom_range(1, 0) == 1);
            bus.rdata = word_at(bus.addr);
            discard   = discard_pending || redirect;

            if (ir_valid && !stall) begin
                total++; if (ir_pc !== model_pc || ir !== word_at(model_pc) || ir_pc4 !== model_pc + 32'd4) begin bad++; $display("FAIL rnd_order cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, ir_pc, ir, ir_pc4, model_pc, word_at(model_pc), model_pc + 32'd4); end
                model_pc = model_pc + 32'd4;
                consumed++;
            end
            if (redirect) model_pc = redirect_pc & 32'hFFFF_FFFC;
            if (bus.ack) discard_pending = 1'b0;
            if (redirect && bus.req && !bus.ack) discard_pending = 1'b1;

            prev_redirect  = redirect;
            prev_req       = bus.req;
            prev_ack       = bus.ack;
            prev_addr      = bus.addr;
            prev_valid     = ir_valid;
            prev_stall     = stall;
            prev_ir        = ir;
            prev_ir_pc     = ir_pc;
            prev_discard   = discard;
            prev_slot_free = !ir_valid || !stall;
        end
        @(negedge clk);
        idle_inputs();
        total++; if (consumed < 300) begin bad++; $display("FAIL rnd_progress got=%0d exp>=300", consumed); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_sequential();
        test_stall_hold();
        test_redirect_pending();
        test_redirect_with_ack();
        test_pc_wrap();
        test_reset_in_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
